// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of a multicycle ARM-style processor: sequences fetch, decode,
// memory, execute, writeback and branch steps, and counts retired instructions.
module multicycle_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        ALUOp,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } stateT;

  stateT       curSt, nxtSt;
  logic [15:0] cntQ;

  assign state       = curSt;
  assign instr_count = cntQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) curSt <= FETCH;
    else        curSt <= nxtSt;
  end

  always_comb begin
    nxtSt      = FETCH;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUOp      = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    instr_done = 1'b0;
    case (curSt)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
        nxtSt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   nxtSt = Funct[5] ? EXECI : EXECR;
          2'b01:   nxtSt = MEMADR;
          2'b10:   nxtSt = BRANCH;
          default: begin
            nxtSt      = FETCH;
            instr_done = 1'b1;  // undefined op retires as a no-op
          end
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        nxtSt   = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        nxtSt  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        MemW       = 1'b1;
        instr_done = mem_ready;
        nxtSt      = mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUOp = 1'b1;
        nxtSt = ALUWB;
      end
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
        nxtSt   = ALUWB;
      end
      ALUWB: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: nxtSt = FETCH;  // illegal codes recover with every enable low
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cntQ <= 16'd0;
    else if (instr_done) cntQ <= cntQ + 16'd1;
  end

endmodule
